// File: rtl/rails_stream_gen.sv
// Stimulus transmitter for the rails checker: simulates the station stack, then streams n and departures.
// Optional self-check outputs (mismatch, err_cnt) are enabled by defining RAILS_GEN_CHECK_EN.
module rails_stream_gen #(
    parameter int MAX_N = 15,
    parameter int OPW   = 2*MAX_N
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [3:0]     n,
    input  logic [OPW-1:0] ops,
    output logic [3:0]     data,
    output logic           data_act,
    input  logic           rails_valid,
    input  logic           rails_result,
    output logic           busy,
    output logic           done,
    output logic           result,
    output logic           cmd_err
`ifdef RAILS_GEN_CHECK_EN
    ,
    output logic           mismatch,
    output logic [15:0]    err_cnt
`endif
);

    localparam int PW = $clog2(MAX_N + 1);
    localparam int CW = $clog2(OPW);
    localparam logic [4:0] MAX_N5 = 5'(MAX_N);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND_NUM,
        SEND_DATA,
        WAIT_RES,
        ERR
    } state_t;

    state_t state, state_d;

    logic [3:0]     n_q;
    logic [OPW-1:0] ops_q;
    logic [PW-1:0]  sp;
    logic [PW-1:0]  next_cnt;
    logic [PW-1:0]  idx;
    logic [CW-1:0]  op_cnt;
    logic [3:0]     stack   [MAX_N];
    logic [3:0]     dep_buf [MAX_N];

    logic       cmd_ok;
    logic       is_push;
    logic       last_op;
    logic       load_err;
    logic [3:0] coach;

    logic [3:0] data_d;
    logic       data_act_d;
    logic       busy_d;
    logic       done_d;
    logic       result_d;
    logic       cmd_err_d;
    logic       mismatch_d;

    assign cmd_ok  = (n != 4'd0) && ({1'b0, n} <= MAX_N5);
    assign is_push = ops_q[op_cnt];
    assign last_op = (op_cnt == CW'({1'b0, n_q, 1'b0} - 6'd1));
    assign coach   = 4'(next_cnt) + 4'd1;

    // The final op must be a pop that empties the stack; anything else leaves coaches stranded.
    assign load_err = (is_push && (next_cnt == PW'(n_q))) ||
                      (!is_push && (sp == '0)) ||
                      (last_op && !(!is_push && (sp == PW'(1))));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:      if (start) state_d = cmd_ok ? LOAD : ERR;
            LOAD:      if (load_err) state_d = ERR;
                       else if (last_op) state_d = SEND_NUM;
            SEND_NUM:  state_d = SEND_DATA;
            SEND_DATA: if (idx == PW'(n_q)) state_d = WAIT_RES;
            WAIT_RES:  if (rails_valid) state_d = IDLE;
            ERR:       state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        data_d     = 4'd0;
        data_act_d = 1'b0;
        done_d     = 1'b0;
        result_d   = result;
        cmd_err_d  = 1'b0;
        mismatch_d = 1'b0;
        busy_d     = (state_d != IDLE);
        case (state)
            LOAD: begin
                if (!load_err && last_op) begin
                    data_d     = n_q;
                    data_act_d = 1'b1;
                end
            end
            SEND_NUM: begin
                data_d     = dep_buf[0];
                data_act_d = 1'b1;
            end
            SEND_DATA: begin
                if (idx != PW'(n_q)) begin
                    data_d     = dep_buf[idx];
                    data_act_d = 1'b1;
                end
            end
            WAIT_RES: begin
                if (rails_valid) begin
                    done_d     = 1'b1;
                    result_d   = rails_result;
                    mismatch_d = !rails_result;
                end
            end
            ERR:     cmd_err_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data     <= 4'd0;
            data_act <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= 1'b0;
            cmd_err  <= 1'b0;
        end else begin
            data     <= data_d;
            data_act <= data_act_d;
            busy     <= busy_d;
            done     <= done_d;
            result   <= result_d;
            cmd_err  <= cmd_err_d;
        end
    end

`ifdef RAILS_GEN_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            mismatch <= 1'b0;
            err_cnt  <= '0;
        end else begin
            mismatch <= mismatch_d;
            if (mismatch_d && (err_cnt != '1)) err_cnt <= err_cnt + 16'd1;
        end
    end
`else
    logic unused_mismatch;
    assign unused_mismatch = mismatch_d;
`endif

    // idx doubles as the departure write pointer in LOAD and the read pointer while streaming.
    always_ff @(posedge clk) begin
        if (reset) begin
            n_q      <= 4'd0;
            ops_q    <= '0;
            sp       <= '0;
            next_cnt <= '0;
            idx      <= '0;
            op_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        n_q      <= n;
                        ops_q    <= ops;
                        sp       <= '0;
                        next_cnt <= '0;
                        idx      <= '0;
                        op_cnt   <= '0;
                    end
                end
                LOAD: begin
                    if (!load_err) begin
                        if (is_push) begin
                            sp       <= sp + PW'(1);
                            next_cnt <= next_cnt + PW'(1);
                        end else begin
                            sp  <= sp - PW'(1);
                            idx <= idx + PW'(1);
                        end
                        op_cnt <= op_cnt + CW'(1);
                        if (last_op) idx <= '0;
                    end
                end
                SEND_NUM:  idx <= idx + PW'(1);
                SEND_DATA: if (idx != PW'(n_q)) idx <= idx + PW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == LOAD && !load_err) begin
            if (is_push) begin
                stack[sp] <= coach;
            end else begin
                dep_buf[idx] <= stack[sp - PW'(1)];
            end
        end
    end

endmodule

// File: tb/tb_rails_stream_gen.sv
// Directed self-checking bench for rails_stream_gen; the checker side is driven by hand.
module tb_rails_stream_gen;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  n;
    logic [29:0] ops;
    logic [3:0]  data;
    logic        data_act;
    logic        rails_valid;
    logic        rails_result;
    logic        busy;
    logic        done;
    logic        result;
    logic        cmd_err;
`ifdef RAILS_GEN_CHECK_EN
    logic        mismatch;
    logic [15:0] err_cnt;
    int          exp_err_cnt = 0;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;

    rails_stream_gen #(.MAX_N(15)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .n            (n),
        .ops          (ops),
        .data         (data),
        .data_act     (data_act),
        .rails_valid  (rails_valid),
        .rails_result (rails_result),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .cmd_err      (cmd_err)
`ifdef RAILS_GEN_CHECK_EN
        ,
        .mismatch     (mismatch),
        .err_cnt      (err_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Start strobe at edge E0; returns at the negedge after E0.
    task automatic issue(input logic [3:0] nn, input logic [29:0] oo);
        start = 1'b1;
        n     = nn;
        ops   = oo;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("done_after_start", 32'(done), 32'd0);
        check("cmd_err_after_start", 32'(cmd_err), 32'd0);
        check("act_after_start", 32'(data_act), 32'd0);
    endtask

    // Checks edges E1..E(3n+1); dep packs departure j at bits [4j+3:4j].
    task automatic stream(input logic [3:0] nn, input logic [59:0] dep, input int poke_k, input int abort_k);
        int nv;
        logic [3:0] ed;
        logic       ea;
        nv = int'(nn);
        for (int k = 1; k <= 3*nv + 1; k++) begin
            @(negedge clk);
            start = (k == poke_k);
            if (k == poke_k) begin
                n   = 4'd1;
                ops = 30'h1;
            end
            if (k < 2*nv) begin
                ed = 4'd0; ea = 1'b0;
            end else if (k == 2*nv) begin
                ed = nn; ea = 1'b1;
            end else if (k <= 3*nv) begin
                ed = dep[4*(k-2*nv-1) +: 4]; ea = 1'b1;
            end else begin
                ed = 4'd0; ea = 1'b0;
            end
            check("stream_data", 32'(data), 32'(ed));
            check("stream_act", 32'(data_act), 32'(ea));
            check("stream_busy", 32'(busy), 32'd1);
            check("stream_cmd_err", 32'(cmd_err), 32'd0);
            if (k == abort_k) begin
                start = 1'b0;
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check("abort_data", 32'(data), 32'd0);
                check("abort_act", 32'(data_act), 32'd0);
                check("abort_busy", 32'(busy), 32'd0);
                return;
            end
        end
        start = 1'b0;
    endtask

    task automatic respond(input int delay, input logic res);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            check("wait_busy", 32'(busy), 32'd1);
            check("wait_done", 32'(done), 32'd0);
        end
        rails_valid  = 1'b1;
        rails_result = res;
        @(negedge clk);
        rails_valid  = 1'b0;
        rails_result = 1'b0;
        check("done_pulse", 32'(done), 32'd1);
        check("result", 32'(result), 32'(res));
        check("busy_at_done", 32'(busy), 32'd0);
`ifdef RAILS_GEN_CHECK_EN
        check("mismatch", 32'(mismatch), 32'(!res));
        if (!res) exp_err_cnt++;
        check("err_cnt", 32'(err_cnt), 32'(exp_err_cnt));
`endif
    endtask

    task automatic err_case(input logic [3:0] nn, input logic [29:0] oo, input int err_edge, input logic exp_res);
        issue(nn, oo);
        for (int k = 1; k <= err_edge; k++) begin
            @(negedge clk);
            check("err_cmd_err", 32'(cmd_err), 32'(k == err_edge));
            check("err_busy", 32'(busy), 32'(k != err_edge));
            check("err_act", 32'(data_act), 32'd0);
            check("err_result", 32'(result), 32'(exp_res));
        end
        @(negedge clk);
        check("err_pulse_end", 32'(cmd_err), 32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        n            = 4'd0;
        ops          = '0;
        rails_valid  = 1'b0;
        rails_result = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data", 32'(data), 32'd0);
        check("rst_act", 32'(data_act), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_cmd_err", 32'(cmd_err), 32'd0);
`ifdef RAILS_GEN_CHECK_EN
        check("rst_mismatch", 32'(mismatch), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
        reset = 1'b0;

        // Checker strobe outside WAIT_RES has no effect.
        rails_valid  = 1'b1;
        rails_result = 1'b1;
        @(negedge clk);
        rails_valid  = 1'b0;
        rails_result = 1'b0;
        check("idle_valid_done", 32'(done), 32'd0);
        check("idle_valid_result", 32'(result), 32'd0);

        // push,pop x3 -> 3,1,2,3
        issue(4'd3, 30'b010101);
        stream(4'd3, 60'h321, 0, 0);
        respond(0, 1'b1);

        // push x3, pop x3 -> 3,3,2,1 ; started on the edge right after done
        issue(4'd3, 30'b000111);
        stream(4'd3, 60'h123, 0, 0);
        respond(5, 1'b1);

        // Illegal commands: pop on empty, n=0, push past n
        err_case(4'd2, 30'b0110, 2, 1'b1);
        err_case(4'd0, 30'b0, 1, 1'b1);
        err_case(4'd1, 30'b11, 3, 1'b1);

        // n=5: ops 0010110101 departs 1,2,4,5,3; a start during SEND_DATA is ignored
        issue(4'd5, 30'b0010110101);
        stream(4'd5, 60'h35421, 12, 0);
        respond(2, 1'b1);

        issue(4'd5, 30'b0011010101);
        stream(4'd5, 60'h45321, 0, 0);
        respond(0, 1'b1);

        // Reset during the third stream word, then a normal command
        issue(4'd3, 30'b010101);
        stream(4'd3, 60'h321, 0, 8);
        issue(4'd3, 30'b010101);
        stream(4'd3, 60'h321, 0, 0);
        respond(1, 1'b0);

        issue(4'd3, 30'b010101);
        stream(4'd3, 60'h321, 0, 0);
        respond(0, 1'b1);

        // Boundaries: n=1 and n=MAX_N
        issue(4'd1, 30'b01);
        stream(4'd1, 60'h1, 0, 0);
        respond(0, 1'b1);

        issue(4'd15, 30'h15555555);
        stream(4'd15, 60'hFEDCBA987654321, 0, 0);
        respond(3, 1'b1);

        @(negedge clk);
        check("final_done", 32'(done), 32'd0);
        check("final_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
